// File: rtl/ifu.sv
// Instruction fetch unit: fetch PC, credit-limited imem requests,
// in-flight PC tracking and a 2-entry instruction buffer toward decode.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] fetch_pc;
    logic [1:0]  outstanding;
    logic [1:0]  discard;
    logic [1:0]  count;
    logic        fifo_head;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic [31:0] pcq        [2];
    logic        pcq_wr;
    logic        pcq_rd;

    logic        pop;
    logic        grant;
    logic        push;
    logic        fifo_wr;
    logic [2:0]  credit;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign pop    = instr_valid_o & instr_ready_i;
    assign credit = {1'b0, outstanding} + {1'b0, count} - {2'b00, pop};

    // A request is only issued if its word is guaranteed a FIFO slot.
    assign imem_req  = rst_n & ~halt_i & ~redirect_i & (credit < 3'd2);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;

    assign push    = imem_rvalid & (discard == 2'd0) & ~redirect_i;
    assign fifo_wr = fifo_head ^ count[0];

    assign instr_valid_o = (count != 2'd0);
    assign instr_o       = instr_valid_o ? fifo_instr[fifo_head] : NOP;
    assign pc_o          = instr_valid_o ? fifo_pc[fifo_head] : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            outstanding <= 2'd0;
            discard     <= 2'd0;
            count       <= 2'd0;
            fifo_head   <= 1'b0;
            pcq_wr      <= 1'b0;
            pcq_rd      <= 1'b0;
        end else begin
            if (redirect_i)
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            else if (grant)
                fetch_pc <= fetch_pc + 32'd4;

            outstanding <= outstanding + {1'b0, grant} - {1'b0, imem_rvalid};

            // Every request still in flight after this cycle is stale.
            if (redirect_i)
                discard <= outstanding - {1'b0, imem_rvalid};
            else if (imem_rvalid && discard != 2'd0)
                discard <= discard - 2'd1;

            if (grant)
                pcq_wr <= ~pcq_wr;
            if (imem_rvalid)
                pcq_rd <= ~pcq_rd;

            if (redirect_i)
                count <= 2'd0;
            else
                count <= count + {1'b0, push} - {1'b0, pop};

            if (pop)
                fifo_head <= ~fifo_head;
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]    <= pcq[pcq_rd];
            fifo_instr[fifo_wr] <= imem_rdata;
        end
    end

endmodule
